// File: rtl/exec_core.sv
// ---------------------------------------------------------------------------
// exec_core
//   Combined decode / execute / memory stage of the 9-bit-instruction,
//   8-bit-data accumulator-style CPU. The instruction is decoded into control
//   strobes and the ALU result and flags are computed. The block also owns the
//   data memory and selects the register write-back value. Decode, ALU and
//   memory read are combinational. Only the memory writes and the memory clear
//   on reset are clocked.
//
// Ports
//   Clk        in   1   clock, rising edge
//   Reset      in   1   synchronous, active-high; clears the whole data memory
//   Instr      in   9   active instruction; 9'h1FF = halt
//   RegA       in   DW  operand A = R[Instr[4:3]] (also the write-back dest)
//   RegB       in   DW  operand B = R[Instr[2:1]]
//   RegWrEn    out  1   write RegWrData into R[Instr[4:3]] at next edge
//   RegWrData  out  DW  ALU result, or memory data for LD/LDX
//   BranchEn   out  1   BZ decoded; PC branches when Zero is also 1
//   Ack        out  1   HALT decoded
//   Zero       out  1   ALU result == 0
//   Parity     out  1   XOR-reduction of ALU result
//   Odd        out  1   ALU result bit 0
//   MemRdData  out  DW  mem[addr], asynchronous read
// ---------------------------------------------------------------------------
module exec_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [8:0]    Instr,
  input  logic [DW-1:0] RegA,
  input  logic [DW-1:0] RegB,
  output logic          RegWrEn,
  output logic [DW-1:0] RegWrData,
  output logic          BranchEn,
  output logic          Ack,
  output logic          Zero,
  output logic          Parity,
  output logic          Odd,
  output logic [DW-1:0] MemRdData
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_LDX  = 4'hD;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;

  localparam int MEM_WORDS = 1 << AW;

  // Even-parity helper: XOR-reduction of a data word.
  function automatic logic calcParity(input logic [DW-1:0] value);
    calcParity = ^value;
  endfunction

  logic [3:0]    opcode;
  logic [DW-1:0] immData;
  logic [AW-1:0] immAddr;
  logic [DW-1:0] aluOut;
  logic          regWrEn;
  logic          branchEn;
  logic          ack;
  logic          memWrEn;
  logic          isLoad;
  logic          useImmAddr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] mem [0:MEM_WORDS-1];

  assign opcode  = Instr[8:5];
  assign immData = {{(DW-3){1'b0}}, Instr[2:0]};
  assign immAddr = {{(AW-3){1'b0}}, Instr[2:0]};

  // Instruction decode and ALU. Ops that do not compute anything pass A
  // through, so the flags stay defined for every encoding.
  always_comb begin
    aluOut     = RegA;
    regWrEn    = 1'b0;
    branchEn   = 1'b0;
    ack        = 1'b0;
    memWrEn    = 1'b0;
    isLoad     = 1'b0;
    useImmAddr = 1'b0;
    case (opcode)
      OP_ADD:  begin aluOut = RegA + RegB;              regWrEn = 1'b1; end
      OP_SUB:  begin aluOut = RegA - RegB;              regWrEn = 1'b1; end
      OP_AND:  begin aluOut = RegA & RegB;              regWrEn = 1'b1; end
      OP_OR:   begin aluOut = RegA | RegB;              regWrEn = 1'b1; end
      OP_XOR:  begin aluOut = RegA ^ RegB;              regWrEn = 1'b1; end
      OP_NOT:  begin aluOut = ~RegA;                    regWrEn = 1'b1; end
      OP_SHL:  begin aluOut = {RegA[DW-2:0], 1'b0};     regWrEn = 1'b1; end
      OP_SHR:  begin aluOut = {1'b0, RegA[DW-1:1]};     regWrEn = 1'b1; end
      OP_ADDI: begin aluOut = RegA + immData;           regWrEn = 1'b1; end
      OP_MOV:  begin aluOut = RegB;                     regWrEn = 1'b1; end
      OP_LDI:  begin aluOut = immData;                  regWrEn = 1'b1; end
      OP_LD:   begin isLoad = 1'b1;                     regWrEn = 1'b1; end
      OP_ST:   begin memWrEn = 1'b1; end
      OP_LDX:  begin isLoad = 1'b1; useImmAddr = 1'b1;  regWrEn = 1'b1; end
      OP_BZ:   begin branchEn = 1'b1; end
      OP_SYS: begin
        // Only the all-ones encoding halts; the rest of the 1111 group is NOP.
        if (Instr[4:0] == 5'b11111) begin
          ack = 1'b1;
        end else begin
          ack = 1'b0;
        end
      end
      default: begin
        aluOut = RegA;
      end
    endcase
  end

  // Data-memory address: LDX uses the immediate, every other op uses B.
  always_comb begin
    if (useImmAddr) begin
      memAddr = immAddr;
    end else begin
      memAddr = RegB[AW-1:0];
    end
  end

  // Data memory. Reset clears every word and takes priority over a store.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= {DW{1'b0}};
      end
    end else if (memWrEn) begin
      mem[memAddr] <= RegA;
    end
  end

  // Asynchronous read. A store to the same address shows the old data
  // until the clock edge.
  assign MemRdData = mem[memAddr];

  // Write-back select and flags.
  always_comb begin
    if (isLoad) begin
      RegWrData = MemRdData;
    end else begin
      RegWrData = aluOut;
    end
  end

  assign RegWrEn  = regWrEn;
  assign BranchEn = branchEn;
  assign Ack      = ack;
  assign Zero     = (aluOut == {DW{1'b0}});
  assign Parity   = calcParity(aluOut);
  assign Odd      = aluOut[0];

endmodule

// File: tb/tb_exec_core.sv
// ---------------------------------------------------------------------------
// tb_exec_core
//   Scoreboard bench for exec_core. Each driven instruction pushes its
//   expected outputs, which come from a reference model and a shadow memory.
//   The entry is popped and compared on the following falling edge. Constant
//   values for the documented example cases are checked in addition.
// ---------------------------------------------------------------------------
module tb_exec_core;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [8:0] Instr = 9'h1FF;
  logic [7:0] RegA = 8'h00;
  logic [7:0] RegB = 8'h00;
  logic       RegWrEn, BranchEn, Ack, Zero, Parity, Odd;
  logic [7:0] RegWrData, MemRdData;

  exec_core #(.DW(8), .AW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .RegA(RegA), .RegB(RegB),
    .RegWrEn(RegWrEn), .RegWrData(RegWrData), .BranchEn(BranchEn),
    .Ack(Ack), .Zero(Zero), .Parity(Parity), .Odd(Odd), .MemRdData(MemRdData)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       wrEn;
    logic [7:0] wrData;
    logic       br;
    logic       ack;
    logic       zero;
    logic       par;
    logic       odd;
    logic [7:0] memRd;
  } expT;

  expT        sbQueue[$];
  logic [7:0] shadowMem [0:255];
  int         totalChecks = 0;
  int         passedChecks = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      passedChecks++;
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [2:0] imm);
    mk = {op, 2'b00, imm};
  endfunction

  // Reference model of one instruction against the shadow memory.
  function automatic expT model(input logic [8:0] ins, input logic [7:0] a, input logic [7:0] b);
    expT        e;
    logic [7:0] o;
    logic [7:0] imm;
    logic [7:0] addr;
    imm  = {5'd0, ins[2:0]};
    addr = (ins[8:5] == 4'hD) ? imm : b;
    o = a;
    e.wrEn = 1'b0; e.br = 1'b0; e.ack = 1'b0;
    case (ins[8:5])
      4'h0: o = a + b;
      4'h1: o = a - b;
      4'h2: o = a & b;
      4'h3: o = a | b;
      4'h4: o = a ^ b;
      4'h5: o = ~a;
      4'h6: o = a << 1;
      4'h7: o = a >> 1;
      4'h8: o = a + imm;
      4'h9: o = b;
      4'hA: o = imm;
      4'hE: e.br = 1'b1;
      4'hF: e.ack = (ins[4:0] == 5'b11111);
      default: o = a;
    endcase
    e.wrEn   = (ins[8:5] <= 4'hB) || (ins[8:5] == 4'hD);
    e.memRd  = shadowMem[addr];
    e.wrData = (ins[8:5] == 4'hB || ins[8:5] == 4'hD) ? e.memRd : o;
    e.zero   = (o == 8'h00);
    e.par    = ^o;
    e.odd    = o[0];
    return e;
  endfunction

  // Drive one instruction, score it; optionally also check RegWrData (kind 1)
  // or Zero (kind 2) against a hand-written constant.
  task automatic drive(input string tag, input logic [8:0] ins, input logic [7:0] a,
                       input logic [7:0] b, input int kind, input logic [7:0] constExp);
    expT e;
    @(posedge Clk);
    #1;
    Instr = ins; RegA = a; RegB = b;
    sbQueue.push_back(model(ins, a, b));
    @(negedge Clk);
    if (sbQueue.size() == 0) begin
      checkVal({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkVal({tag, "/wrEn"},   {31'd0, RegWrEn},  {31'd0, e.wrEn});
      checkVal({tag, "/wrData"}, {24'd0, RegWrData}, {24'd0, e.wrData});
      checkVal({tag, "/br"},     {31'd0, BranchEn}, {31'd0, e.br});
      checkVal({tag, "/ack"},    {31'd0, Ack},      {31'd0, e.ack});
      checkVal({tag, "/zero"},   {31'd0, Zero},     {31'd0, e.zero});
      checkVal({tag, "/par"},    {31'd0, Parity},   {31'd0, e.par});
      checkVal({tag, "/odd"},    {31'd0, Odd},      {31'd0, e.odd});
      checkVal({tag, "/memRd"},  {24'd0, MemRdData}, {24'd0, e.memRd});
    end
    if (kind == 1) checkVal({tag, "/const"}, {24'd0, RegWrData}, {24'd0, constExp});
    if (kind == 2) checkVal({tag, "/constZ"}, {31'd0, Zero}, {31'd0, constExp[0]});
    // A store lands at the next rising edge, which the next step waits for.
    if (ins[8:5] == 4'hC) shadowMem[b] = a;
  endtask

  // Two reset cycles: the first carries a store that must be ignored, the
  // second carries HALT, which must still decode during reset.
  task automatic doReset();
    @(posedge Clk);
    #1;
    Reset = 1'b1; Instr = mk(4'hC, 3'd0); RegA = 8'hFF; RegB = 8'h10;
    @(posedge Clk);
    #1;
    Instr = 9'h1FF;
    @(negedge Clk);
    checkVal("reset/ack",  {31'd0, Ack},     32'd1);
    checkVal("reset/wrEn", {31'd0, RegWrEn}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 256; i++) shadowMem[i] = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadowMem[i] = 8'h00;
    // Reset is held from time zero, so memory is cleared at the first edge.
    @(negedge Clk);
    checkVal("init/ack",  {31'd0, Ack},     32'd1);
    checkVal("init/wrEn", {31'd0, RegWrEn}, 32'd0);
    checkVal("init/br",   {31'd0, BranchEn}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    drive("add_wrap", mk(4'h0, 3'd0), 8'hF0, 8'h20, 1, 8'h10);
    drive("sub_zero", mk(4'h1, 3'd0), 8'h05, 8'h05, 2, 8'h01);
    drive("bz_zero",  mk(4'hE, 3'd0), 8'h00, 8'h00, 2, 8'h01);
    drive("bz_nz",    mk(4'hE, 3'd0), 8'h03, 8'h00, 2, 8'h00);
    drive("st_5a",    mk(4'hC, 3'd0), 8'h5A, 8'h10, 0, 8'h00);
    drive("ld_5a",    mk(4'hB, 3'd0), 8'h00, 8'h10, 1, 8'h5A);
    drive("st_33",    mk(4'hC, 3'd0), 8'h33, 8'h03, 0, 8'h00);
    drive("ldx_33",   mk(4'hD, 3'd3), 8'h00, 8'hEE, 1, 8'h33);
    drive("shl",      mk(4'h6, 3'd0), 8'h81, 8'h00, 1, 8'h02);
    drive("shr",      mk(4'h7, 3'd0), 8'h81, 8'h00, 1, 8'h40);
    drive("addi",     mk(4'h8, 3'd3), 8'hFE, 8'h00, 1, 8'h01);
    drive("ldi",      mk(4'hA, 3'd7), 8'h99, 8'h00, 1, 8'h07);
    drive("and",      mk(4'h2, 3'd0), 8'hCC, 8'hAA, 1, 8'h88);
    drive("or",       mk(4'h3, 3'd0), 8'hC0, 8'h0A, 1, 8'hCA);
    drive("xor",      mk(4'h4, 3'd0), 8'hFF, 8'h0F, 1, 8'hF0);
    drive("not",      mk(4'h5, 3'd0), 8'h0F, 8'h00, 1, 8'hF0);
    drive("mov",      mk(4'h9, 3'd0), 8'h11, 8'h77, 1, 8'h77);
    drive("nop",      9'h1E0,          8'h42, 8'h00, 0, 8'h00);
    drive("halt",     9'h1FF,          8'h42, 8'h00, 0, 8'h00);
    // Read during write: the second store's cycle still shows 8'h5A.
    drive("st_rdw",   mk(4'hC, 3'd0), 8'hA5, 8'h10, 0, 8'h00);
    drive("ld_rdw",   mk(4'hB, 3'd0), 8'h00, 8'h10, 1, 8'hA5);

    doReset();
    drive("ld_after_rst",  mk(4'hB, 3'd0), 8'h00, 8'h10, 1, 8'h00);
    drive("ldx_after_rst", mk(4'hD, 3'd3), 8'h00, 8'h00, 1, 8'h00);

    // Random mix; stores and loads concentrate on a few addresses so that
    // loads hit previously written words.
    for (int i = 0; i < 60; i++) begin
      logic [8:0] ins;
      logic [7:0] b;
      ins = 9'($urandom_range(0, 511));
      b   = 8'($urandom_range(0, 255));
      if (ins[8:5] == 4'hC || ins[8:5] == 4'hB) b = {5'd0, b[2:0]};
      drive("rand", ins, 8'($urandom_range(0, 255)), b, 0, 8'h00);
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

  // Safety net against a hung simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
